triad_decoder_bank: RTL and testbench
=====================================

Name: triad_decoder_bank

Overview:
- Parametrised bank of NCH distrip triad decoders with the persistence stretch built in.
- Each channel deserialises a 3-bit triad (start, strip, half-strip) into a 4-bit one-hot half-strip hit and holds it for a programmable number of clocks.
- Each channel flags triads skipped while its hit is held, and keeps a saturating skip counter with a per-channel enable mask.
- Sits between the comparator distrip inputs and the half-strip compare / error-count logic. Runs in the 40 MHz LCT domain.

Parameters:
- NCH, 8, number of distrip channels (1..32)
- PW, 4, width of the persistence setting
- CW, 16, width of each skip counter

Ports:
- clk  in  1  LCT clock, all logic on rising edge
- _reset  in  1  synchronous active-low reset
- distrip  in  NCH  serial triad input, one bit per channel
- chan_mask  in  NCH  1 = channel enabled
- persist  in  PW  hit hold length minus 1 (0 means a 1-clock hit)
- skip_cnt_clr  in  1  synchronous clear of all skip counters
- halfstrips  out  4*NCH  channel c drives bits [4c+3:4c]; bit index = {strip_bit, hs_bit}
- triad_skip  out  NCH  1-clock pulse per skipped triad
- any_skip  out  1  registered OR of triad_skip
- hit_any  out  1  registered OR of halfstrips
- skip_cnt  out  CW*NCH  channel c counter at [CW*c+CW-1:CW*c]

Behaviour:
- Reset (_reset=0 at an edge): all channels go to IDLE. halfstrips, triad_skip, any_skip, hit_any, every skip_cnt and the hold counters all become 0.
- Per-channel FSM states and transitions:
  - IDLE: distrip=1 -> STRIP. Otherwise stay in IDLE.
  - STRIP: capture distrip as strip_bit -> HS.
  - HS: capture distrip as hs_bit; latch persist into hold_cnt -> HOLD.
  - HOLD: hold_cnt==0 -> IDLE. Otherwise decrement hold_cnt.
- Output timing:
  - halfstrips is registered. The one-hot {strip,hs} bit is high exactly while the channel is in HOLD, which is persist+1 clocks.
  - Start bit sampled at edge k -> hit visible after edge k+3.
- The persist value is latched at HS. Changing persist mid-hold does not alter the current hit.
- Back-to-back triads: a start bit in the first IDLE cycle after HOLD is accepted. Minimum triad period is persist+4 clocks.
- Skip detection: distrip=1 while in HOLD, including the final HOLD cycle, is a skip.
  - triad_skip[c] pulses for 1 clock on the following edge.
  - skip_cnt[c] increments on the same edge.
  - The FSM does not restart; the skipped bit is discarded.
- Counter rules:
  - skip_cnt saturates at 2^CW-1 and does not wrap.
  - skip_cnt_clr and a skip on the same edge: counter = 0, and the triad_skip pulse is still emitted.
- Masking:
  - chan_mask[c]=0 forces IDLE on the next edge, even mid-triad or mid-hold.
  - While masked, the channel's halfstrips and triad_skip are 0, distrip is ignored, and skip_cnt holds its value (still clearable).
  - Unmasking starts the channel from IDLE.
- Reset asserted mid-operation: outputs are 0 after that edge, regardless of state.
- any_skip and hit_any lag triad_skip and halfstrips by 1 clock.

Decomposition:
- Shared package/header comptest_pkg: FSM state encodings (IDLE=0, STRIP=1, HS=2, HOLD=3), default PW/CW, TRIAD_LEN=3.
- One sub-module, triad_chan, holds the single-channel FSM, hold counter, skip pulse and saturating counter.
- triad_decoder_bank is a generate loop over triad_chan plus the two OR-reduction registers.

Test Plan:
- persist=0, ch0 distrip=1,1,0 from edge k -> halfstrips[3:0]=4'b0100 for exactly 1 clock after edge k+3. All other channels 0. hit_any=1 one clock later.
- persist=5, ch3 distrip=1,0,1 -> halfstrips[15:12]=4'b0010 for 6 clocks. distrip=1 at hold cycles 2 and 6 -> two triad_skip[3] pulses, skip_cnt[3]=2, hit unchanged.
- CW=4, 20 skips on ch1 -> skip_cnt[1] saturates at 15. Then skip_cnt_clr coincident with a skip -> counter 0 and the triad_skip pulse still present.
- Triad started on ch2, chan_mask[2] dropped at the HS cycle -> no hit, and no skip for 10 clocks of distrip=1. Remask to 1 -> next triad 1,1,1 gives halfstrips[11:8]=4'b1000.
- _reset=0 during HOLD with persist=15 -> all outputs 0 after that edge. A start bit on the first cycle after reset release decodes normally.
- persist changed from 7 to 0 during HOLD -> current hit still lasts 8 clocks. Next triad lasts 1 clock. Back-to-back triads at period persist+4 produce no skips.

Source files
------------

// File: rtl/comptest_pkg.sv
// Shared definitions for the distrip triad decoder bank.
// Holds the per-channel FSM state encoding, the default widths of the
// persistence setting and the skip counters, and the triad length.
package comptest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STRIP = 2'd1,
        ST_HS    = 2'd2,
        ST_HOLD  = 2'd3
    } triad_state_e;

    localparam int PW_DEFAULT = 4;
    localparam int CW_DEFAULT = 16;
    localparam int TRIAD_LEN  = 3;

endpackage

// File: rtl/triad_chan.sv
// Single distrip channel: deserialises a start/strip/half-strip triad into a
// one-hot half-strip hit, stretches the hit for persist+1 clocks, flags and
// counts triads that arrive while the hit is still being held.
//
// Ports:
//   clk           LCT clock
//   _reset        synchronous active-low reset
//   distrip       serial triad bit for this channel
//   enable        channel mask bit, 0 forces IDLE and silences outputs
//   persist       hit hold length minus 1, latched at the half-strip bit
//   skip_cnt_clr  synchronous clear of the skip counter
//   halfstrips    registered one-hot hit, index {strip_bit, hs_bit}
//   triad_skip    1-clock pulse per skipped triad
//   skip_cnt      saturating count of skipped triads
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for a start bit
// STRIP | next distrip bit is the strip bit
// HS    | next distrip bit is the half-strip bit
// HOLD  | hit held, hold_cnt clocks remain after this one
module triad_chan
    import comptest_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          _reset,
    input  logic          distrip,
    input  logic          enable,
    input  logic [PW-1:0] persist,
    input  logic          skip_cnt_clr,
    output logic [3:0]    halfstrips,
    output logic          triad_skip,
    output logic [CW-1:0] skip_cnt
);

    localparam logic [PW-1:0] HOLD_STEP = 1;
    localparam logic [CW-1:0] CNT_STEP  = 1;

    triad_state_e  state, state_nxt;
    logic [PW-1:0] hold_cnt, hold_cnt_nxt;
    logic          strip_bit, hs_bit;
    logic          skip;
    logic [3:0]    hit_onehot;

    assign hit_onehot = 4'b0001 << {strip_bit, hs_bit};

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        skip         = 1'b0;
        if (!enable) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE:  if (distrip) state_nxt = ST_STRIP;
                ST_STRIP: state_nxt = ST_HS;
                ST_HS: begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = persist;
                end
                ST_HOLD: begin
                    // A start bit during the hold (final cycle included) is
                    // discarded; the current hit runs to completion.
                    skip = distrip;
                    if (hold_cnt == '0) state_nxt = ST_IDLE;
                    else                hold_cnt_nxt = hold_cnt - HOLD_STEP;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            strip_bit  <= 1'b0;
            hs_bit     <= 1'b0;
            halfstrips <= '0;
            triad_skip <= 1'b0;
            skip_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            if (enable && state == ST_STRIP) strip_bit <= distrip;
            if (enable && state == ST_HS)    hs_bit    <= distrip;
            // Hit lags the HOLD state by one clock, giving the k+3 latency.
            halfstrips <= (enable && state == ST_HOLD) ? hit_onehot : 4'b0000;
            triad_skip <= skip;
            // Clear wins over a coincident skip; the pulse is still emitted.
            if (skip_cnt_clr)
                skip_cnt <= '0;
            else if (skip && skip_cnt != '1)
                skip_cnt <= skip_cnt + CNT_STEP;
        end
    end

endmodule

// File: rtl/triad_decoder_bank.sv
// Bank of NCH distrip triad decoders with hit stretching and skip counting,
// plus registered OR summaries of the hits and skip pulses.
//
// Ports:
//   clk           LCT clock
//   _reset        synchronous active-low reset
//   distrip       serial triad input, one bit per channel
//   chan_mask     1 = channel enabled
//   persist       hit hold length minus 1
//   skip_cnt_clr  synchronous clear of all skip counters
//   halfstrips    channel c at [4c+3:4c]
//   triad_skip    per-channel skip pulse
//   any_skip      registered OR of triad_skip
//   hit_any       registered OR of halfstrips
//   skip_cnt      channel c counter at [CW*c+CW-1:CW*c]
module triad_decoder_bank
    import comptest_pkg::*;
#(
    parameter int NCH = 8,
    parameter int PW  = PW_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic [NCH-1:0]    distrip,
    input  logic [NCH-1:0]    chan_mask,
    input  logic [PW-1:0]     persist,
    input  logic              skip_cnt_clr,
    output logic [4*NCH-1:0]  halfstrips,
    output logic [NCH-1:0]    triad_skip,
    output logic              any_skip,
    output logic              hit_any,
    output logic [CW*NCH-1:0] skip_cnt
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        triad_chan #(
            .PW(PW),
            .CW(CW)
        ) u_chan (
            .clk          (clk),
            ._reset       (_reset),
            .distrip      (distrip[c]),
            .enable       (chan_mask[c]),
            .persist      (persist),
            .skip_cnt_clr (skip_cnt_clr),
            .halfstrips   (halfstrips[4*c +: 4]),
            .triad_skip   (triad_skip[c]),
            .skip_cnt     (skip_cnt[CW*c +: CW])
        );
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            any_skip <= 1'b0;
            hit_any  <= 1'b0;
        end else begin
            any_skip <= |triad_skip;
            hit_any  <= |halfstrips;
        end
    end

endmodule

// File: tb/tb_triad_decoder_bank.sv
// Self-checking bench for triad_decoder_bank: directed scenarios followed by
// randomized traffic, all compared each clock against a timeline model that
// tracks each triad by its start cycle.
module tb_triad_decoder_bank;

    localparam int NCH = 8;
    localparam int PW  = 4;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst_v = 1'b0;
    logic [NCH-1:0]    d_v = '0;
    logic [NCH-1:0]    mask_v = '1;
    logic [PW-1:0]     persist_v = '0;
    logic              clr_v = 1'b0;
    logic [4*NCH-1:0]  halfstrips;
    logic [NCH-1:0]    triad_skip;
    logic              any_skip;
    logic              hit_any;
    logic [CW*NCH-1:0] skip_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    triad_decoder_bank #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
        .clk          (clk),
        ._reset       (rst_v),
        .distrip      (d_v),
        .chan_mask    (mask_v),
        .persist      (persist_v),
        .skip_cnt_clr (clr_v),
        .halfstrips   (halfstrips),
        .triad_skip   (triad_skip),
        .any_skip     (any_skip),
        .hit_any      (hit_any),
        .skip_cnt     (skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each active triad is described by its start cycle,
    // the decoded half-strip index and the hold length latched at offset 2.
    logic [4*NCH-1:0]  e_hs = '0;
    logic [NCH-1:0]    e_skip = '0;
    logic              e_any_skip = 1'b0;
    logic              e_hit_any = 1'b0;
    logic [CW*NCH-1:0] e_cnt = '0;
    bit                m_act[NCH];
    int                m_start[NCH];
    int                m_len[NCH];
    bit [1:0]          m_idx[NCH];
    int                m_cnt[NCH];
    int                n_cyc = 0;

    function automatic void model_step();
        int o;
        e_hit_any  = rst_v ? (|e_hs) : 1'b0;
        e_any_skip = rst_v ? (|e_skip) : 1'b0;
        for (int c = 0; c < NCH; c++) begin
            e_hs[4*c +: 4] = 4'b0000;
            e_skip[c]      = 1'b0;
            if (!rst_v) begin
                m_act[c] = 1'b0;
                m_cnt[c] = 0;
            end else if (!mask_v[c]) begin
                m_act[c] = 1'b0;
                if (clr_v) m_cnt[c] = 0;
            end else begin
                if (m_act[c]) begin
                    o = n_cyc - m_start[c];
                    if (o == 1) begin
                        m_idx[c][1] = d_v[c];
                    end else if (o == 2) begin
                        m_idx[c][0] = d_v[c];
                        m_len[c]    = int'(persist_v);
                    end else begin
                        e_hs[4*c +: 4] = 4'b0001 << m_idx[c];
                        e_skip[c]      = d_v[c];
                        if (o == 3 + m_len[c]) m_act[c] = 1'b0;
                    end
                end else if (d_v[c]) begin
                    m_act[c]   = 1'b1;
                    m_start[c] = n_cyc;
                end
                if (clr_v) m_cnt[c] = 0;
                else if (e_skip[c] && m_cnt[c] < (2**CW) - 1) m_cnt[c]++;
            end
            e_cnt[CW*c +: CW] = CW'(m_cnt[c]);
        end
        n_cyc++;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("halfstrips", 64'(halfstrips), 64'(e_hs));
        check_eq("triad_skip", 64'(triad_skip), 64'(e_skip));
        check_eq("any_skip",   64'(any_skip),   64'(e_any_skip));
        check_eq("hit_any",    64'(hit_any),    64'(e_hit_any));
        check_eq("skip_cnt",   64'(skip_cnt),   64'(e_cnt));
    endtask

    task automatic drive(input logic [NCH-1:0] d, input int n);
        d_v = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    int hits;

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 1'b0; m_start[c] = 0; m_len[c] = 0; m_idx[c] = 2'b00; m_cnt[c] = 0;
        end
        drive('0, 2);
        check_eq("reset_hs", 64'(halfstrips), 64'd0);
        check_eq("reset_cnt", 64'(skip_cnt), 64'd0);
        rst_v = 1'b1;
        mask_v = '1;

        // persist=0, ch0 triad 1,1,0 -> 4'b0100 for one clock
        persist_v = 4'd0;
        drive(8'h01, 2); drive(8'h00, 1);
        drive(8'h00, 1);
        check_eq("p0_hit", 64'(halfstrips), 64'h4);
        drive(8'h00, 1);
        check_eq("p0_hit_any", 64'(hit_any), 64'd1);
        check_eq("p0_hit_end", 64'(halfstrips), 64'd0);

        // persist=5, ch3 triad 1,0,1 with skips at hold cycles 2 and 6
        persist_v = 4'd5;
        drive(8'h08, 1); drive(8'h00, 1); drive(8'h08, 1);
        drive(8'h00, 1);
        check_eq("p5_hit", 64'(halfstrips[15:12]), 64'h2);
        drive(8'h08, 1); drive(8'h00, 3); drive(8'h08, 1);
        drive(8'h00, 4);
        check_eq("p5_skips", 64'(skip_cnt[CW*3 +: CW]), 64'd2);

        // ch1 saturation at 15, then clear coincident with a skip
        persist_v = 4'd15;
        drive(8'h02, 19); drive(8'h00, 1);
        drive(8'h02, 3); drive(8'h02, 4);
        check_eq("sat_cnt", 64'(skip_cnt[CW*1 +: CW]), 64'd15);
        clr_v = 1'b1;
        drive(8'h02, 1);
        clr_v = 1'b0;
        check_eq("clr_pulse", 64'(triad_skip[1]), 64'd1);
        check_eq("clr_cnt", 64'(skip_cnt[CW*1 +: CW]), 64'd0);
        drive(8'h00, 16);

        // ch2 masked at its HS cycle, then re-enabled with triad 1,1,1
        persist_v = 4'd3;
        drive(8'h04, 2);
        mask_v = 8'hFB;
        drive(8'h04, 11);
        check_eq("mask_hs", 64'(halfstrips[11:8]), 64'd0);
        check_eq("mask_cnt", 64'(skip_cnt[CW*2 +: CW]), 64'd0);
        mask_v = 8'hFF;
        drive(8'h04, 3); drive(8'h00, 1);
        check_eq("unmask_hit", 64'(halfstrips[11:8]), 64'h8);
        drive(8'h00, 4);

        // reset during a persist=15 hold, then a start right after release
        persist_v = 4'd15;
        drive(8'h01, 1); drive(8'h00, 1); drive(8'h01, 1); drive(8'h00, 5);
        rst_v = 1'b0;
        drive(8'h00, 1);
        check_eq("rst_hs", 64'(halfstrips), 64'd0);
        check_eq("rst_cnt", 64'(skip_cnt), 64'd0);
        rst_v = 1'b1;
        drive(8'h01, 2); drive(8'h00, 1); drive(8'h00, 1);
        check_eq("post_rst_hit", 64'(halfstrips[3:0]), 64'h4);
        drive(8'h00, 16);

        // persist 7 -> 0 mid-hold on ch5, then back-to-back triads at period 4
        persist_v = 4'd7;
        drive(8'h20, 1); drive(8'h00, 2);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) persist_v = 4'd0;
            drive(8'h00, 1);
            if (halfstrips[23:20] != 4'b0000) hits++;
        end
        check_eq("p7_len", 64'(hits), 64'd8);
        hits = 0;
        for (int r = 0; r < 4; r++) begin
            drive(8'h20, 1); if (halfstrips[23:20] != 4'b0000) hits++;
            drive(8'h20, 1); if (halfstrips[23:20] != 4'b0000) hits++;
            drive(8'h00, 1); if (halfstrips[23:20] != 4'b0000) hits++;
            drive(8'h00, 1); if (halfstrips[23:20] != 4'b0000) hits++;
        end
        drive(8'h00, 1); if (halfstrips[23:20] != 4'b0000) hits++;
        check_eq("b2b_hits", 64'(hits), 64'd4);
        check_eq("b2b_skips", 64'(skip_cnt[CW*5 +: CW]), 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst_v = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) mask_v[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) persist_v = PW'($urandom);
            clr_v = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCH; c++) d_v[c] = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
